// File: rtl/fft_pkg.sv
// fft_pkg: shared FFT sizing constants, LUT select codes and sequencer state type
package fft_pkg;
  localparam int LOG2N     = 4;
  localparam int N         = 1 << LOG2N;
  localparam int TW_W      = 16;
  localparam int TW_ADDR_W = 4;
  localparam int STAGE_W   = 2;
  localparam logic REAL = 1'b0;
  localparam logic IMAG = 1'b1;
  typedef enum logic [2:0] {IDLE, FETCH_RE, FETCH_IM, WAIT_IM, ISSUE, DONE} state_t;
endpackage

// File: rtl/fft_bf_addr_gen.sv
// fft_bf_addr_gen: stage/group/butterfly counters producing radix-2 DIT addresses and twiddle index
// Ports: clr restarts at (s,g,j)=0; advance steps to the next butterfly;
//        a/b butterfly addresses, k twiddle index, stage, last = final butterfly;
//        k_nxt (TWIDDLE_CACHE_EN builds only) = twiddle index after the pending advance.
module fft_bf_addr_gen
  import fft_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 advance,
  output logic [LOG2N-1:0]     a,
  output logic [LOG2N-1:0]     b,
  output logic [TW_ADDR_W-1:0] k,
`ifdef TWIDDLE_CACHE_EN
  output logic [TW_ADDR_W-1:0] k_nxt,
`endif
  output logic [STAGE_W-1:0]   stage,
  output logic                 last
);
  logic [LOG2N-1:0] j_q, j_d, g_q, g_d, half, g_max;
  logic [STAGE_W-1:0] s_q, s_d;
  logic j_end, g_end, s_end;
  always_comb begin
    half  = LOG2N'(1) << s_q;
    g_max = LOG2N'(N / 2 - 1) >> s_q;
    j_end = j_q == half - 1'b1;
    g_end = g_q == g_max;
    s_end = s_q == STAGE_W'(LOG2N - 1);
    last  = j_end && g_end && s_end;
    j_d   = clr ? '0 : advance ? (j_end ? '0 : j_q + 1'b1) : j_q;
    g_d   = clr ? '0 : (advance && j_end) ? (g_end ? '0 : g_q + 1'b1) : g_q;
    s_d   = clr ? '0 : (advance && j_end && g_end) ? (s_end ? '0 : s_q + 1'b1) : s_q;
    a     = ((g_q << s_q) << 1) | j_q;
    b     = a | half;
    k     = TW_ADDR_W'(j_q << (STAGE_W'(LOG2N - 1) - s_q));
`ifdef TWIDDLE_CACHE_EN
    k_nxt = TW_ADDR_W'(j_d << (STAGE_W'(LOG2N - 1) - s_d));
`endif
    stage = s_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      j_q <= '0;
      g_q <= '0;
      s_q <= '0;
    end else begin
      j_q <= j_d;
      g_q <= g_d;
      s_q <= s_d;
    end
  end
endmodule

// File: rtl/fft_twiddle_sequencer.sv
// fft_twiddle_sequencer: walks every radix-2 DIT butterfly, fetches its twiddle and issues it over valid/ready
// Ports: start/busy/done to FFT control; lut_real_imag/lut_twiddle_num/lut_twiddle_val to the
//        registered twiddle LUT; bf_* descriptor (addresses, twiddle, stage, last) to the butterfly unit.
// Build option: TWIDDLE_CACHE_EN skips the LUT fetch when the next k equals the last fetched k.
module fft_twiddle_sequencer
  import fft_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 lut_real_imag,
  output logic [TW_ADDR_W-1:0] lut_twiddle_num,
  input  logic [TW_W-1:0]      lut_twiddle_val,
  output logic                 bf_valid,
  input  logic                 bf_ready,
  output logic [LOG2N-1:0]     bf_addr_a,
  output logic [LOG2N-1:0]     bf_addr_b,
  output logic [TW_W-1:0]      bf_tw_re,
  output logic [TW_W-1:0]      bf_tw_im,
  output logic [STAGE_W-1:0]   bf_stage,
  output logic                 bf_last
);
  state_t state_q, state_d;
  logic [TW_W-1:0] tw_re_q, tw_re_d, tw_im_q, tw_im_d;
  logic [LOG2N-1:0] a, b;
  logic [TW_ADDR_W-1:0] k;
  logic [STAGE_W-1:0] stage;
  logic last, clr, hs, hit, issue, fetch;
`ifdef TWIDDLE_CACHE_EN
  logic [TW_ADDR_W-1:0] k_nxt, last_k_q, last_k_d;
  logic cache_valid_q, cache_valid_d;
`endif
  fft_bf_addr_gen u_gen (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .advance (hs),
    .a       (a),
    .b       (b),
    .k       (k),
`ifdef TWIDDLE_CACHE_EN
    .k_nxt   (k_nxt),
`endif
    .stage   (stage),
    .last    (last)
  );
  always_comb begin
    issue   = state_q == ISSUE;
    fetch   = state_q == FETCH_RE || state_q == FETCH_IM;
    hs      = issue && bf_ready;
    clr     = state_q == IDLE && start;
`ifdef TWIDDLE_CACHE_EN
    hit           = cache_valid_q && k_nxt == last_k_q;
    cache_valid_d = clr ? 1'b0 : state_q == WAIT_IM ? 1'b1 : cache_valid_q;
    last_k_d      = state_q == WAIT_IM ? k : last_k_q;
`else
    hit     = 1'b0;
`endif
    // LUT data lags its request by one cycle: real arrives during FETCH_IM, imag during WAIT_IM
    tw_re_d = state_q == FETCH_IM ? lut_twiddle_val : tw_re_q;
    tw_im_d = state_q == WAIT_IM ? lut_twiddle_val : tw_im_q;
    unique case (state_q)
      IDLE:     state_d = start ? FETCH_RE : IDLE;
      FETCH_RE: state_d = FETCH_IM;
      FETCH_IM: state_d = WAIT_IM;
      WAIT_IM:  state_d = ISSUE;
      ISSUE:    state_d = hs ? (last ? DONE : hit ? ISSUE : FETCH_RE) : ISSUE;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      tw_re_q       <= '0;
      tw_im_q       <= '0;
`ifdef TWIDDLE_CACHE_EN
      last_k_q      <= '0;
      cache_valid_q <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      tw_re_q       <= tw_re_d;
      tw_im_q       <= tw_im_d;
`ifdef TWIDDLE_CACHE_EN
      last_k_q      <= last_k_d;
      cache_valid_q <= cache_valid_d;
`endif
    end
  end
  // descriptor fields read as zero whenever no descriptor is offered
  assign busy            = state_q != IDLE && state_q != DONE;
  assign done            = state_q == DONE;
  assign lut_real_imag   = state_q == FETCH_IM ? IMAG : REAL;
  assign lut_twiddle_num = fetch ? k : '0;
  assign bf_valid        = issue;
  assign bf_addr_a       = issue ? a : '0;
  assign bf_addr_b       = issue ? b : '0;
  assign bf_tw_re        = issue ? tw_re_q : '0;
  assign bf_tw_im        = issue ? tw_im_q : '0;
  assign bf_stage        = issue ? stage : '0;
  assign bf_last         = issue && last;
endmodule

// File: tb/tb_fft_twiddle_sequencer.sv
// tb_fft_twiddle_sequencer: directed table-driven check of descriptor order, twiddles, timing, stalls and resets
module tb_fft_twiddle_sequencer;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, bf_ready = 1'b1;
  logic busy, done, lut_real_imag, bf_valid, bf_last;
  logic [3:0] lut_twiddle_num, bf_addr_a, bf_addr_b;
  logic [15:0] lut_twiddle_val, bf_tw_re, bf_tw_im;
  logic [1:0] bf_stage;

  fft_twiddle_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .lut_real_imag(lut_real_imag), .lut_twiddle_num(lut_twiddle_num),
    .lut_twiddle_val(lut_twiddle_val), .bf_valid(bf_valid), .bf_ready(bf_ready),
    .bf_addr_a(bf_addr_a), .bf_addr_b(bf_addr_b), .bf_tw_re(bf_tw_re),
    .bf_tw_im(bf_tw_im), .bf_stage(bf_stage), .bf_last(bf_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) lut_twiddle_val <= lut_real_imag ? 16'h2000 + 16'(lut_twiddle_num)
                                                         : 16'h1000 + 16'(lut_twiddle_num);

`ifdef TWIDDLE_CACHE_EN
  localparam int EXP_DONE = 104;
  localparam int EXP_FETCH = 24;
`else
  localparam int EXP_DONE = 128;
  localparam int EXP_FETCH = 32;
`endif

  typedef struct {
    logic [3:0] a, b, k;
    logic [1:0] s;
    logic       last;
  } desc_t;
  desc_t exp_d[32];

  int tests = 0, fails = 0;
  int ncyc = 0, idx = 0, ndone = 0, nfetch = 0, done_ncyc = 0, start_ncyc = 0;
  logic prev_stall = 1'b0;
  logic [43:0] prev_f;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got %h expected %h", name, got, want);
    end
  endtask

  always @(posedge clk) ncyc <= ncyc + 1;

  function automatic logic [50:0] all_out();
    return {busy, done, lut_real_imag, lut_twiddle_num, bf_valid, bf_addr_a, bf_addr_b,
            bf_tw_re, bf_tw_im, bf_stage, bf_last};
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (prev_stall) chk("stall_hold", {bf_valid, bf_addr_a, bf_addr_b, bf_tw_re, bf_tw_im, bf_stage, bf_last}, prev_f);
      if (bf_valid && bf_ready) begin
        if (idx < 32)
          chk($sformatf("desc%0d", idx), {bf_addr_a, bf_addr_b, bf_tw_re, bf_tw_im, bf_stage, bf_last},
              {exp_d[idx].a, exp_d[idx].b, 16'h1000 + 16'(exp_d[idx].k), 16'h2000 + 16'(exp_d[idx].k),
               exp_d[idx].s, exp_d[idx].last});
        else
          chk("desc_overflow", 64'(idx), 64'd31);
        idx++;
      end
      if (done) begin
        ndone++;
        done_ncyc = ncyc;
      end
      if (lut_real_imag) nfetch++;
      prev_stall = bf_valid && !bf_ready;
      prev_f = {bf_valid, bf_addr_a, bf_addr_b, bf_tw_re, bf_tw_im, bf_stage, bf_last};
    end else prev_stall = 1'b0;
  end

  task automatic run(input bit rnd, input bit poke, input string tag);
    bit seen = 1'b0;
    idx = 0; ndone = 0; nfetch = 0;
    @(negedge clk);
    start = 1'b1;
    start_ncyc = ncyc + 1;
    for (int c = 0; c < 2000 && !seen; c++) begin
      @(posedge clk); #1;
      start = poke && (c == 60);
      bf_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      seen = done;
    end
    chk({tag, "_done_seen"}, 64'(seen), 64'd1);
    if (poke) begin
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk({tag, "_start_in_done"}, 64'(busy), 64'd0);
      repeat (10) @(posedge clk);
      #1 chk({tag, "_no_rerun"}, {62'd0, busy, bf_valid}, 64'd0);
    end else repeat (3) @(posedge clk);
    bf_ready = 1'b1;
    #1;
    chk({tag, "_count"}, 64'(idx), 64'd32);
    chk({tag, "_done_pulses"}, 64'(ndone), 64'd1);
    chk({tag, "_fetches"}, 64'(nfetch), 64'(EXP_FETCH));
    if (!rnd) chk({tag, "_done_cycle"}, 64'(done_ncyc - start_ncyc), 64'(EXP_DONE));
  endtask

  initial begin
    int n = 0;
    for (int s = 0; s < 4; s++)
      for (int g = 0; g < 16 / (2 << s); g++)
        for (int j = 0; j < (1 << s); j++) begin
          exp_d[n].a = 4'(g * (2 << s) + j);
          exp_d[n].b = 4'(g * (2 << s) + j + (1 << s));
          exp_d[n].k = 4'(j << (3 - s));
          exp_d[n].s = 2'(s);
          exp_d[n].last = n == 31;
          n++;
        end
    repeat (3) @(negedge clk);
    chk("reset_outputs", 64'(all_out()), 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_outputs", 64'(all_out()), 64'd0);
    run(1'b0, 1'b0, "full");
    run(1'b1, 1'b0, "rand_ready");
    run(1'b0, 1'b1, "start_busy");
    idx = 0; ndone = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 500 && !(bf_valid && bf_stage == 2'd2); c++) @(posedge clk);
    chk("reach_stage2", {62'd0, bf_valid, bf_stage == 2'd2}, 64'd3);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_reset_outputs", 64'(all_out()), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("mid_reset_idle", {62'd0, busy, bf_valid}, 64'd0);
    chk("mid_reset_no_done", 64'(ndone), 64'd0);
    run(1'b0, 1'b0, "after_reset");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
